// File: rtl/serial_compare_arbiter.sv
// Two-requester round-robin arbiter feeding a bit-serial, MSB-first unsigned magnitude comparator.
// A grant is offered combinationally in IDLE; the winner's operands are taken on the edge that ends the grant cycle.
module serial_compare_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             cur_id;
    logic             last_id;
    logic [1:0]       rst_sync;
    logic             rst_ok;
    logic             pick0, pick1, grant_en;
    logic             bit_a, bit_b;

    // Reset release is synchronised: no grant can be offered until two clean edges have passed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ok = rst_sync[1];

    // Handshake: reqN is a level held until gntN; gntN is high for exactly the one IDLE cycle whose closing edge transfers the operands.
    assign pick0    = req0 & (~req1 | last_id);
    assign pick1    = req1 & ~pick0;
    assign grant_en = (state == IDLE) & rst_ok;
    assign gnt0     = grant_en & pick0;
    assign gnt1     = grant_en & pick1;

    assign bit_a     = a_q[cnt];
    assign bit_b     = b_q[cnt];
    assign done      = (state == DONE);
    assign busy      = (state != IDLE) | gnt0 | gnt1;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt0 | gnt1) state_nxt = CMP;
            CMP:     if ((bit_a != bit_b) || (cnt == '0)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            cur_id  <= 1'b0;
            last_id <= 1'b1;
            done_id <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (gnt0 | gnt1) begin
                a_q     <= gnt1 ? a1 : a0;
                b_q     <= gnt1 ? b1 : b0;
                cnt     <= CW'(WIDTH - 1);
                cur_id  <= gnt1;
                last_id <= gnt1;
            end
            // Result flags and owner only move on the edge into DONE, so they hold between done pulses.
            if (state == CMP) begin
                if (bit_a != bit_b) begin
                    gt      <= bit_a;
                    lt      <= bit_b;
                    eq      <= 1'b0;
                    done_id <= cur_id;
                end else if (cnt == '0) begin
                    eq      <= 1'b1;
                    gt      <= 1'b0;
                    lt      <= 1'b0;
                    done_id <= cur_id;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/serial_compare_arbiter.md
SERIAL_COMPARE_ARBITER -- requirements
Module: serial_compare_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0  input  1  requester 0 compare request, level, held until gnt0.
REQ-006 a0, b0  input  WIDTH each  requester 0 operands, valid while req0=1.
REQ-007 req1  input  1  requester 1 compare request, level, held until gnt1.
REQ-008 a1, b1  input  WIDTH each  requester 1 operands, valid while req1=1.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands latched on the same edge.
REQ-010 busy  output  1  high from the grant cycle through the done cycle inclusive.
REQ-011 done  output  1  one-cycle result-valid pulse.
REQ-012 done_id  output  1  requester index owning the current result.
REQ-013 eq, gt, lt  output  1 each  result flags for a vs b, unsigned; exactly one high after the first done.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CMP, DONE.
REQ-015 In IDLE with req0|req1, the next edge SHALL latch the winner's operands, pulse its gnt for one cycle, load bit counter to WIDTH-1, and enter CMP.
REQ-016 Arbitration SHALL be round-robin: a sole requester wins; with both requesting, the winner is the requester not served last.
REQ-017 The last-served pointer SHALL update only on a grant.
REQ-018 In IDLE with no request, state, gnt and busy SHALL be unchanged/low.
REQ-019 In CMP, each cycle SHALL examine latched bit [cnt] of a and b, MSB first.
REQ-020 Bits differ: set gt=a[cnt], lt=b[cnt], eq=0, enter DONE.
REQ-021 Bits equal and cnt=0: set eq=1, gt=0, lt=0, enter DONE.
REQ-022 Bits equal and cnt>0: decrement cnt and remain in CMP.
REQ-023 CMP duration SHALL be (WIDTH - index of highest differing bit) cycles, or WIDTH cycles when equal; no other stall.
REQ-024 DONE SHALL last exactly one cycle, with done=1 and done_id set, then return to IDLE.
REQ-025 eq/gt/lt and done_id SHALL be registered and held unchanged from done until the next done.
REQ-026 Total latency from grant edge to done edge SHALL be CMP cycles + 1; back-to-back throughput requires one IDLE cycle between DONE and the next grant.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; input operand changes after grant SHALL NOT affect the result.
REQ-028 A request dropped before grant SHALL be discarded without a grant.
REQ-029 A request still high one cycle after its own grant SHALL be treated as a new request.
REQ-030 gnt0 and gnt1 SHALL never be high together, and done SHALL never coincide with a gnt.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, eq=0, gt=0, lt=0, cnt=0, operand registers=0.
REQ-032 After reset, the last-served pointer SHALL equal 1, so requester 0 wins the first simultaneous request.
REQ-033 Reset asserted mid-CMP SHALL abort the operation with no done pulse; deassertion SHALL be synchronised to clk internally.

Verification (WIDTH=8)
REQ-034 req0, a0=0xA5, b0=0x25 -> gnt0 pulse, 1 CMP cycle, done next cycle, gt=1, done_id=0.
REQ-035 req1, a1=0x3C, b1=0x3C -> 8 CMP cycles, then done with eq=1, done_id=1; busy high for 10 cycles.
REQ-036 req0 and req1 held together from reset -> grants in order 0,1,0,1; each done_id matches its grant; lt/gt correct per operands.
REQ-037 req0 with a0=0x01, b0=0x02, a0 changed to 0xFF after gnt0 -> lt=1 after 7 CMP cycles.
REQ-038 rst_n pulsed low during the 4th CMP cycle -> all outputs 0 immediately, no done, and the next request completes normally.
REQ-039 req1 raised and dropped while busy -> no gnt1, no spurious done.
